// File: rtl/maxp_reduce_pkg.sv
// Shared build defaults for the max-pool reduce slice.
// Define MAXP_RELU_EN to clamp negative window maxima to zero at the write register.
package maxp_reduce_pkg;

    localparam int DATA_SIZE_DEF = 16;
    localparam int LOOP_BIT_DEF  = 8;
    localparam int ADDR_BIT_DEF  = 20;
    localparam int RD_LAT_DEF    = 2;

    // Flag bits carried alongside the indices: {vld, first, last}
    localparam int FLAG_W = 3;

    // Width that holds (mm*nOR + niro)*nOC + nico without overflow
    function automatic int prod_w(input int loop_bit, input int data_size);
        return loop_bit + 2 * data_size + 2;
    endfunction

endpackage

// File: rtl/maxp_dly.sv
// Parameterised shift register used to line the index/flag stream up with read data.
// Every stage is cleared on reset so no stale valid bit survives a reset.
module maxp_dly #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    // NOTE: the whole pipe is reset, not just the valid bits; it is small and a
    // cleared pipe keeps the aligned-stage indices deterministic after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/maxp_reduce.sv
// Max-pool reduce: folds each MPxMP window of read data to its signed maximum and
// issues one output write per window. Optional MAXP_RELU_EN clamps negatives to 0.
module maxp_reduce
    import maxp_reduce_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int LOOP_BIT  = LOOP_BIT_DEF,
    parameter int ADDR_BIT  = ADDR_BIT_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] MP,
    input  logic [DATA_SIZE-1:0] nOR,
    input  logic [DATA_SIZE-1:0] nOC,
    input  logic [LOOP_BIT-1:0]  mm,
    input  logic [LOOP_BIT-1:0]  niro,
    input  logic [LOOP_BIT-1:0]  nico,
    input  logic [LOOP_BIT-1:0]  ii,
    input  logic [LOOP_BIT-1:0]  jj,
    input  logic [DATA_SIZE-1:0] din,
    output logic                 wr_en,
    output logic [ADDR_BIT-1:0]  wr_addr,
    output logic [DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0] win_cnt
);

    localparam int PW = prod_w(LOOP_BIT, DATA_SIZE);
    localparam int SW = FLAG_W + 3 * LOOP_BIT;

    logic [DATA_SIZE-1:0] mp_m1;
    logic                 first_in;
    logic                 last_in;
    logic [SW-1:0]        stage_in;
    logic [SW-1:0]        stage_out;

    logic                 a_vld;
    logic                 a_first;
    logic                 a_last;
    logic [LOOP_BIT-1:0]  a_mm;
    logic [LOOP_BIT-1:0]  a_niro;
    logic [LOOP_BIT-1:0]  a_nico;

    logic [DATA_SIZE-1:0] acc;
    logic [DATA_SIZE-1:0] cur_max;
    logic [DATA_SIZE-1:0] wr_data_nxt;
    logic [PW-1:0]        addr_full;

    // Window position flags are decided at issue time, where ii/jj are valid
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mp_m1    = MP - DATA_SIZE'(1);
        first_in = (ii == '0) && (jj == '0);
        last_in  = (DATA_SIZE'(ii) == mp_m1) && (DATA_SIZE'(jj) == mp_m1);
        stage_in = {en, first_in, last_in, mm, niro, nico};
    end

    maxp_dly #(
        .WIDTH (SW),
        .DEPTH (RD_LAT)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .d   (stage_in),
        .q   (stage_out)
    );

    assign a_vld   = stage_out[SW-1];
    assign a_first = stage_out[SW-2];
    assign a_last  = stage_out[SW-3];
    assign a_mm    = stage_out[3*LOOP_BIT-1 -: LOOP_BIT];
    assign a_niro  = stage_out[2*LOOP_BIT-1 -: LOOP_BIT];
    assign a_nico  = stage_out[LOOP_BIT-1:0];

    // Running max including the current element; a tie keeps acc
    always_comb begin
        cur_max = acc;
        if (a_first || ($signed(din) > $signed(acc))) cur_max = din;

        addr_full = (PW'(a_mm) * PW'(nOR) + PW'(a_niro)) * PW'(nOC) + PW'(a_nico);

`ifdef MAXP_RELU_EN
        wr_data_nxt = cur_max[DATA_SIZE-1] ? '0 : cur_max;
`else
        wr_data_nxt = cur_max;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            win_cnt <= '0;
        end else begin
            wr_en <= a_vld && a_last;
            if (a_vld) acc <= cur_max;
            if (a_vld && a_last) begin
                wr_data <= wr_data_nxt;
                wr_addr <= addr_full[ADDR_BIT-1:0];
                win_cnt <= win_cnt + DATA_SIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_maxp_reduce.sv
// Directed self-checking bench for maxp_reduce; read data is modelled as a
// memory returning din RD_LAT cycles after the index issue.
module tb_maxp_reduce;

    localparam int DS = 16;
    localparam int LB = 8;
    localparam int AB = 20;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DS-1:0] MP = 16'd2;
    logic [DS-1:0] nOR = 16'd2;
    logic [DS-1:0] nOC = 16'd2;
    logic [LB-1:0] mm = '0, niro = '0, nico = '0, ii = '0, jj = '0;
    logic [DS-1:0] din;
    logic [DS-1:0] din_src = '0;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [DS-1:0] wr_data;
    logic [DS-1:0] win_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [AB-1:0] addr;
        logic [DS-1:0] data;
        logic [DS-1:0] cnt;
        int            cyc;
    } wr_t;
    wr_t wq[$];

    maxp_reduce #(
        .DATA_SIZE (DS),
        .LOOP_BIT  (LB),
        .ADDR_BIT  (AB),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .MP      (MP),
        .nOR     (nOR),
        .nOC     (nOC),
        .mm      (mm),
        .niro    (niro),
        .nico    (nico),
        .ii      (ii),
        .jj      (jj),
        .din     (din),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .win_cnt (win_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-port model: data issued with the indices comes back RD_LAT cycles later
    logic [DS-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= din_src;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign din = rd_pipe[RD_LAT-1];

    always @(negedge clk) begin
        if (wr_en === 1'b1) wq.push_back('{wr_addr, wr_data, win_cnt, cyc});
    end

    // Drive one cycle of loop output; returns the edge count at which en was sampled
    task automatic put(input logic e, input int m, input int nr, input int nc,
                       input int i, input int j, input int d, output int en_cyc);
        en      = e;
        mm      = LB'(m);
        niro    = LB'(nr);
        nico    = LB'(nc);
        ii      = LB'(i);
        jj      = LB'(j);
        din_src = DS'(d);
        @(posedge clk);
        #1;
        en_cyc = cyc;
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        int c;
        for (int k = 0; k < n; k++) put(1'b0, 0, 0, 0, 0, 0, 0, c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
        n_tests++;
        if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        n_tests++;
        if (wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %0d want 0", wr_data); end
        n_tests++;
        if (win_cnt !== '0) begin n_fail++; $display("FAIL reset_win_cnt: got %0d want 0", win_cnt); end
        do_reset();
    endtask

    // One 2x2 window at (mm, niro, nico); checks a single write of want_data/want_addr
    task automatic run_window(input string name, input int m, input int nr, input int nc,
                              input int d0, input int d1, input int d2, input int d3,
                              input int want_data, input int want_addr);
        int c;
        int dv[4];
        dv = '{d0, d1, d2, d3};
        do_reset();
        MP = 16'd2; nOR = 16'd2; nOC = 16'd2;
        for (int k = 0; k < 4; k++) put(1'b1, m, nr, nc, k / 2, k % 2, dv[k], c);
        idle(RD_LAT + 4);
        n_tests++;
        if (wq.size() != 1) begin n_fail++; $display("FAIL %s_count: got %0d want 1", name, wq.size()); end
        if (wq.size() >= 1) begin
            n_tests++;
            if (wq[0].data !== DS'(want_data)) begin
                n_fail++; $display("FAIL %s_data: got %0d want %0d", name, $signed(wq[0].data), want_data);
            end
            n_tests++;
            if (wq[0].addr !== AB'(want_addr)) begin
                n_fail++; $display("FAIL %s_addr: got %0d want %0d", name, wq[0].addr, want_addr);
            end
            n_tests++;
            if (wq[0].cnt !== 16'd1) begin n_fail++; $display("FAIL %s_cnt: got %0d want 1", name, wq[0].cnt); end
            // en sampled at edge c; the write cycle begins at edge c+RD_LAT (RD_LAT+1 cycles after the en cycle)
            n_tests++;
            if (wq[0].cyc != c + RD_LAT) begin
                n_fail++; $display("FAIL %s_latency: got edge %0d want %0d", name, wq[0].cyc, c + RD_LAT);
            end
        end
    endtask

    task automatic test_basic();
        run_window("basic", 0, 1, 1, 3, -5, 9, 1, 9, 3);
    endtask

    task automatic test_negative();
`ifdef MAXP_RELU_EN
        run_window("negative", 1, 0, 1, -7, -2, -9, -4, 0, 5);
`else
        run_window("negative", 1, 0, 1, -7, -2, -9, -4, -2, 5);
`endif
    endtask

    task automatic test_mp1();
        int c, c0;
        do_reset();
        MP = 16'd1; nOR = 16'd2; nOC = 16'd2;
        for (int k = 0; k < 4; k++) begin
            put(1'b1, 0, 0, k, 0, 0, 5 + k, c);
            if (k == 0) c0 = c;
        end
        idle(RD_LAT + 4);
        n_tests++;
        if (wq.size() != 4) begin n_fail++; $display("FAIL mp1_count: got %0d want 4", wq.size()); end
        for (int k = 0; k < 4 && k < wq.size(); k++) begin
            n_tests++;
            if (wq[k].data !== DS'(5 + k) || wq[k].addr !== AB'(k) || wq[k].cnt !== DS'(k + 1)) begin
                n_fail++;
                $display("FAIL mp1_write%0d: got data %0d addr %0d cnt %0d want %0d %0d %0d",
                         k, wq[k].data, wq[k].addr, wq[k].cnt, 5 + k, k, k + 1);
            end
            n_tests++;
            if (wq[k].cyc != c0 + RD_LAT + k) begin
                n_fail++; $display("FAIL mp1_cycle%0d: got %0d want %0d", k, wq[k].cyc, c0 + RD_LAT + k);
            end
        end
    endtask

    task automatic test_gap();
        int c;
        do_reset();
        MP = 16'd2; nOR = 16'd2; nOC = 16'd2;
        put(1'b1, 0, 0, 0, 0, 0, 1, c);
        put(1'b1, 0, 0, 0, 0, 1, 4, c);
        // Bubbles carry large data and a "last" position; both must be ignored
        for (int k = 0; k < 3; k++) put(1'b0, 0, 0, 0, 1, 1, 100, c);
        put(1'b1, 0, 0, 0, 1, 0, 2, c);
        put(1'b1, 0, 0, 0, 1, 1, 0, c);
        idle(RD_LAT + 4);
        n_tests++;
        if (wq.size() != 1) begin n_fail++; $display("FAIL gap_count: got %0d want 1", wq.size()); end
        if (wq.size() >= 1) begin
            n_tests++;
            if (wq[0].data !== 16'd4) begin n_fail++; $display("FAIL gap_data: got %0d want 4", wq[0].data); end
            n_tests++;
            if (wq[0].cyc != c + RD_LAT) begin
                n_fail++; $display("FAIL gap_latency: got %0d want %0d", wq[0].cyc, c + RD_LAT);
            end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        do_reset();
        MP = 16'd2; nOR = 16'd2; nOC = 16'd2;
        put(1'b1, 0, 0, 0, 0, 0, 9, c);
        put(1'b1, 0, 0, 0, 0, 1, 7, c);
        rst = 1'b1;
        #1;
        n_tests++;
        if (win_cnt !== '0 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async: got cnt %0d wr_en %0b want 0 0", win_cnt, wr_en);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) put(1'b1, 0, 0, 1, k / 2, k % 2, 2, c);
        idle(RD_LAT + 4);
        n_tests++;
        if (wq.size() != 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", wq.size()); end
        if (wq.size() >= 1) begin
            n_tests++;
            if (wq[0].data !== 16'd2 || wq[0].cnt !== 16'd1 || wq[0].addr !== 20'd1) begin
                n_fail++;
                $display("FAIL rstmid_write: got data %0d cnt %0d addr %0d want 2 1 1",
                         wq[0].data, wq[0].cnt, wq[0].addr);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int dv[8];
        dv = '{1, 2, 3, 4, 8, 0, 0, 0};
        do_reset();
        MP = 16'd2; nOR = 16'd2; nOC = 16'd2;
        for (int k = 0; k < 8; k++) put(1'b1, 0, 0, k / 4, (k % 4) / 2, k % 2, dv[k], c);
        idle(RD_LAT + 4);
        n_tests++;
        if (wq.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", wq.size()); end
        if (wq.size() >= 2) begin
            n_tests++;
            if (wq[0].data !== 16'd4 || wq[0].addr !== 20'd0) begin
                n_fail++; $display("FAIL b2b_first: got data %0d addr %0d want 4 0", wq[0].data, wq[0].addr);
            end
            n_tests++;
            if (wq[1].data !== 16'd8 || wq[1].addr !== 20'd1) begin
                n_fail++; $display("FAIL b2b_second: got data %0d addr %0d want 8 1", wq[1].data, wq[1].addr);
            end
            n_tests++;
            if (wq[1].cyc - wq[0].cyc != 4) begin
                n_fail++; $display("FAIL b2b_spacing: got %0d want 4", wq[1].cyc - wq[0].cyc);
            end
            n_tests++;
            if (wq[1].cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 2", wq[1].cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_mp1();
        test_gap();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
